// File: rtl/fetch_stage_pkg.sv
// Shared types and helpers for the instruction fetch front end.
// The buffered entry pairs an instruction word with the PC it was fetched from.
package fetch_stage_pkg;

  localparam int unsigned INSTRUCTION_BYTES = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
  } fetch_entry_s;

  // Clears the byte-offset bits so every fetch address is word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'(INSTRUCTION_BYTES - 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, instruction} entries.
// A flush empties it and wins over push; a pop in the flush cycle is absorbed.
module fetch_fifo
  import fetch_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push,
  input  fetch_entry_s           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output fetch_entry_s           head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_s    mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: storage is reset as well so the head, and therefore pc_o and
      // instruction_o, read as zero straight out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      // Stale entries stay in storage; moving the read pointer makes them unreachable.
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values, whatever order these statements appear in.
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch front end: issues in-order word requests, buffers the
// responses and presents them to decode; a taken redirect flushes and refetches.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_address_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  input  logic        jump_target_valid_i,
  input  logic [31:0] jump_target_i,
  input  logic        stall_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] instruction_o
);

  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int CW1 = CW + 1;

  logic [31:0]  fetch_pc;
  logic [31:0]  rsp_pc;
  logic [31:0]  target_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_next;
  logic [CW-1:0] drop;
  logic [CW-1:0] occupancy;
  logic [CW1-1:0] credits_used;
  logic         req_hs;
  logic         deq;
  logic         redirect;
  logic         enq;
  logic         fifo_full;
  logic         fifo_empty;
  fetch_entry_s enq_entry;
  fetch_entry_s head;

  // Every outstanding request owns a FIFO slot, so a response can never find it full.
  // A dequeue frees its slot only on the following cycle.
  assign credits_used       = CW1'(outstanding) + CW1'(occupancy);
  assign imem_req_valid_o   = !rst_i && (credits_used < CW1'(FIFO_DEPTH));
  assign imem_req_address_o = fetch_pc;
  assign req_hs             = imem_req_valid_o && imem_req_ready_i;

  assign deq       = valid_o && !stall_i;
  assign redirect  = jump_target_valid_i && deq;
  assign target_pc = word_align(jump_target_i);

  assign outstanding_next = outstanding + CW'(req_hs) - CW'(imem_rsp_valid_i);
  assign enq              = imem_rsp_valid_i && (drop == '0) && !redirect;
  assign enq_entry        = '{pc: rsp_pc, instruction: imem_rsp_data_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (redirect) begin
        // Everything still in flight, including a request made this cycle, is stale.
        fetch_pc <= target_pc;
        rsp_pc   <= target_pc;
        drop     <= outstanding_next;
      end else begin
        if (req_hs) begin
          fetch_pc <= fetch_pc + 32'(INSTRUCTION_BYTES);
        end
        if (enq) begin
          rsp_pc <= rsp_pc + 32'(INSTRUCTION_BYTES);
        end
        if (imem_rsp_valid_i && (drop != '0)) begin
          drop <= drop - CW'(1);
        end
      end
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push     (enq),
    .push_data(enq_entry),
    .pop      (deq),
    .flush    (redirect),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (occupancy)
  );

  assign valid_o       = !fifo_empty;
  assign pc_o          = head.pc;
  assign instruction_o = head.instruction;

  a_rsp_needs_request : assert property (@(posedge clk_i) disable iff (rst_i)
    imem_rsp_valid_i |-> (outstanding != '0));

  a_drop_bounded : assert property (@(posedge clk_i) disable iff (rst_i)
    drop <= outstanding);

  a_addr_stable : assert property (@(posedge clk_i) disable iff (rst_i)
    (imem_req_valid_o && !imem_req_ready_i && !redirect) |=> $stable(imem_req_address_o));

  a_no_push_when_full : assert property (@(posedge clk_i) disable iff (rst_i)
    !(enq && fifo_full));

endmodule

// File: tb/tb_fetch_stage.sv
// Randomised bench for fetch_stage: an in-order memory model with random
// latency/ready, and a scoreboard of the architectural instruction stream.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i = 1'b0;
  logic [31:0] imem_req_address_o;
  logic        imem_rsp_valid_i = 1'b0;
  logic [31:0] imem_rsp_data_i = '0;
  logic        jump_target_valid_i = 1'b0;
  logic [31:0] jump_target_i = '0;
  logic        stall_i = 1'b0;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] instruction_o;

  fetch_stage #(
    .RESET_PC  (RESET_PC),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .imem_req_valid_o   (imem_req_valid_o),
    .imem_req_ready_i   (imem_req_ready_i),
    .imem_req_address_o (imem_req_address_o),
    .imem_rsp_valid_i   (imem_rsp_valid_i),
    .imem_rsp_data_i    (imem_rsp_data_i),
    .jump_target_valid_i(jump_target_valid_i),
    .jump_target_i      (jump_target_i),
    .stall_i            (stall_i),
    .valid_o            (valid_o),
    .pc_o               (pc_o),
    .instruction_o      (instruction_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    int unsigned due;
    logic [31:0] data;
  } mem_t;

  exp_t exp_q[$];
  mem_t mem_q[$];

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned last_due = 0;

  int          lat_max   = 1;
  int          ready_pct = 100;
  int          stall_pct = 0;
  int          jump_pct  = 0;
  bit          force_stall = 1'b0;
  bit          force_jump  = 1'b0;
  bit          rst_cmd     = 1'b1;
  logic [31:0] force_target = '0;

  logic [31:0] gen_pc = RESET_PC;
  logic [31:0] exp_req_addr = RESET_PC;
  logic [31:0] redirect_pc = '0;
  bit          redirect_now = 1'b0;
  bit          release_cycle = 1'b0;

  // Instruction memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back('{pc: gen_pc, instr: mem_word(gen_pc)});
      gen_pc += 32'd4;
    end
  endtask

  // One clock cycle of stimulus: memory responses and decode inputs after the
  // edge, request capture at mid-cycle.
  task automatic step();
    bit   prev_rst;
    exp_t keep;
    int unsigned due;
    @(posedge clk_i);
    #1;
    cyc++;
    prev_rst      = rst_i;
    rst_i         = rst_cmd;
    redirect_now  = 1'b0;
    release_cycle = prev_rst && !rst_i;
    if (rst_i) begin
      mem_q.delete();
      last_due = 0;
      exp_q.delete();
      gen_pc              = RESET_PC;
      exp_req_addr        = RESET_PC;
      imem_rsp_valid_i    = 1'b0;
      imem_req_ready_i    = 1'b0;
      jump_target_valid_i = 1'b0;
      stall_i             = 1'b0;
    end else begin
      if (release_cycle) begin
        check("reset_valid_o", 32'(valid_o), 32'd0);
        check("reset_pc_o", pc_o, 32'd0);
        check("reset_instruction_o", instruction_o, 32'd0);
        check("reset_req_address", imem_req_address_o, RESET_PC);
      end
      if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = mem_q[0].data;
        void'(mem_q.pop_front());
      end else begin
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = $urandom;
      end
      imem_req_ready_i = ($urandom_range(99) < ready_pct);
      stall_i          = force_stall || ($urandom_range(99) < stall_pct);
      if (force_jump) begin
        jump_target_valid_i = 1'b1;
        jump_target_i       = force_target;
      end else begin
        jump_target_valid_i = ($urandom_range(99) < jump_pct);
        jump_target_i = ($urandom_range(7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      end
      refill();
      if (jump_target_valid_i && valid_o && !stall_i) begin
        // The head (the jump itself) is still consumed; the stream then restarts at the target.
        redirect_now = 1'b1;
        redirect_pc  = {jump_target_i[31:2], 2'b00};
        keep = exp_q[0];
        exp_q.delete();
        exp_q.push_back(keep);
        gen_pc = redirect_pc;
        refill();
      end
    end
    @(negedge clk_i);
    if (rst_i) begin
      check("req_valid_in_reset", 32'(imem_req_valid_o), 32'd0);
    end else begin
      if (release_cycle) check("first_req_valid", 32'(imem_req_valid_o), 32'd1);
      if (imem_req_valid_o && imem_req_ready_i) begin
        check("req_address", imem_req_address_o, exp_req_addr);
        exp_req_addr += 32'd4;
        due = cyc + 32'($urandom_range(lat_max, 1));
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mem_q.push_back('{due: due, data: mem_word(imem_req_address_o)});
      end
      if (redirect_now) exp_req_addr = redirect_pc;
    end
  endtask

  // Monitor: every instruction decode accepts must be the next one of the stream.
  initial begin
    int   idle;
    exp_t e;
    idle = 0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        idle = 0;
      end else if (valid_o && !stall_i) begin
        idle = 0;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got pc_o=%h, required no output", pc_o);
        end else begin
          e = exp_q.pop_front();
          check("pc_o", pc_o, e.pc);
          check("instruction_o", instruction_o, e.instr);
        end
      end else if (!stall_i) begin
        idle++;
        if (idle >= 200) begin
          checks++;
          errors++;
          $display("FAIL liveness: got %0d idle cycles, required fewer than 200", idle);
          idle = 0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no completion, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_cmd = 1'b1;
    repeat (3) step();

    // Release with a 1-cycle memory, always ready, no stall.
    rst_cmd = 1'b0;
    step();
    step();
    check("valid_o_one_after_release", 32'(valid_o), 32'd0);
    step();
    check("valid_o_two_after_release", 32'(valid_o), 32'd1);
    check("first_pc_o", pc_o, RESET_PC);
    repeat (20) step();

    // Long stall: buffer fills, requests stop, then drains back to back.
    force_stall = 1'b1;
    repeat (5) step();
    check("stall_req_valid", 32'(imem_req_valid_o), 32'd0);
    check("stall_valid_o", 32'(valid_o), 32'd1);
    force_stall = 1'b0;
    step();
    check("drain_valid_0", 32'(valid_o), 32'd1);
    step();
    check("drain_valid_1", 32'(valid_o), 32'd1);
    repeat (10) step();

    // Jump under stall is ignored; then a misaligned jump is taken.
    force_stall  = 1'b1;
    force_jump   = 1'b1;
    force_target = 32'h0000_0200;
    repeat (3) step();
    force_stall  = 1'b0;
    force_target = 32'h0000_0102;
    step();
    force_jump = 1'b0;
    repeat (20) step();

    // Reset mid-stream with a full buffer.
    force_stall = 1'b1;
    repeat (4) step();
    rst_cmd     = 1'b1;
    force_stall = 1'b0;
    step();
    step();
    check("midreset_valid_o", 32'(valid_o), 32'd0);
    rst_cmd = 1'b0;
    repeat (30) step();

    // Random traffic with occasional resets.
    lat_max   = 4;
    ready_pct = 70;
    stall_pct = 25;
    jump_pct  = 6;
    for (int i = 0; i < 3; i++) begin
      repeat (1500) step();
      rst_cmd = 1'b1;
      step();
      rst_cmd = 1'b0;
    end

    // Dense redirects on a fast memory.
    lat_max   = 1;
    ready_pct = 100;
    stall_pct = 0;
    jump_pct  = 20;
    repeat (1000) step();

    jump_pct = 0;
    repeat (20) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
